uart_tx_unit: RTL and testbench

UART transmit unit: buffers bytes from the system side in a synchronous FIFO and serialises each one as an 11-bit frame on `tx`.
- Frame: start bit, 8 data bits LSB first, even parity bit, stop bit.
- It is the transmit-side counterpart of the UART receive path and uses the same frame format, so its output is accepted by that receiver.
- Bit timing comes from a baud-tick enable, so the whole block runs on the single system clock.

---
 rtl/uart_tx_unit.sv | 196 +++++++++++++++++++
 tb/tb_uart_tx_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_unit.sv
// UART transmitter: byte FIFO feeding an 11-bit frame serialiser (start, 8 data LSB-first, even parity, stop).
// Latency: a byte written on cycle N can start its frame on the first tx_tick from cycle N+1; one line bit per tick.
// Backpressure: tx_full is high when FIFO_DEPTH bytes are queued; a write while full is silently dropped.
module uart_tx_unit #(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_tick,
    input  logic                  wen,
    input  logic [FIFO_WIDTH-1:0] write_data,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic                  tx_full,
    output logic                  tx_empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic [FIFO_WIDTH-1:0] head;
    logic                  push;
    logic                  pop;

    // Full is judged on the registered count, so a write in the same cycle as
    // a pop from a full FIFO is still refused.
    assign tx_full  = (count == FULL_CNT);
    assign tx_empty = (count == '0);
    assign push     = wen && !tx_full;
    assign head     = mem[rd_ptr];

    // Storage array carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= write_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame serialiser
    // ------------------------------------------------------------------
    state_t     state;
    state_t     state_nxt;
    logic [7:0] shift;
    logic [7:0] shift_nxt;
    logic [2:0] bit_idx;
    logic [2:0] bit_idx_nxt;
    logic       parity;
    logic       parity_nxt;
    logic       tx_nxt;
    logic       done_nxt;
    logic       load;

    // A new byte is taken on a tick from IDLE, or straight out of STOP so
    // consecutive frames abut with no idle bit.
    assign load = tx_tick && !tx_empty && ((state == IDLE) || (state == STOP));

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shift   <= '0;
            bit_idx <= '0;
            parity  <= 1'b0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            shift   <= shift_nxt;
            bit_idx <= bit_idx_nxt;
            parity  <= parity_nxt;
            tx      <= tx_nxt;
            tx_busy <= (state_nxt != IDLE);
            tx_done <= done_nxt;
        end
    end

    // Next-state: the FSM only moves on baud ticks.
    always_comb begin
        state_nxt = state;
        if (tx_tick) begin
            case (state)
                IDLE: begin
                    if (!tx_empty) begin
                        state_nxt = START;
                    end
                end
                START: begin
                    state_nxt = DATA;
                end
                DATA: begin
                    if (bit_idx == 3'd7) begin
                        state_nxt = PARITY;
                    end
                end
                PARITY: begin
                    state_nxt = STOP;
                end
                STOP: begin
                    state_nxt = tx_empty ? IDLE : START;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Outputs and datapath updates: each tick drives the next line bit, so
    // tx changes on the same edge as the tick that ends the previous bit.
    always_comb begin
        pop         = 1'b0;
        tx_nxt      = tx;
        shift_nxt   = shift;
        bit_idx_nxt = bit_idx;
        parity_nxt  = parity;
        done_nxt    = 1'b0;
        if (tx_tick) begin
            case (state)
                IDLE: begin
                    tx_nxt = 1'b1;
                end
                START: begin
                    tx_nxt      = shift[0];
                    bit_idx_nxt = 3'd0;
                end
                DATA: begin
                    if (bit_idx != 3'd7) begin
                        // shift[1] is the bit that becomes shift[0] after this shift.
                        shift_nxt   = {1'b0, shift[7:1]};
                        bit_idx_nxt = bit_idx + 3'd1;
                        tx_nxt      = shift[1];
                    end else begin
                        tx_nxt = parity;
                    end
                end
                PARITY: begin
                    tx_nxt = 1'b1;
                end
                STOP: begin
                    done_nxt = 1'b1;
                    tx_nxt   = 1'b1;
                end
                default: begin
                    tx_nxt = 1'b1;
                end
            endcase
            if (load) begin
                pop        = 1'b1;
                shift_nxt  = head[7:0];
                parity_nxt = ^head[7:0];
                tx_nxt     = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_unit.sv
// Directed bench for uart_tx_unit: captures line bits on every baud tick and compares frames.
// Ticks come from a divide-by-16 generator that can be paused, plus a one-shot manual tick.
// Each scenario task performs its own inline comparisons.
module tb_uart_tx_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_tick = 1'b0;
    logic       wen = 1'b0;
    logic [7:0] write_data = 8'h00;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_full;
    logic       tx_empty;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int done_cnt = 0;
    bit tick_en  = 1'b0;
    bit manual_tick = 1'b0;
    int tick_div = 0;

    uart_tx_unit #(.FIFO_WIDTH(8), .FIFO_DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_tick    (tx_tick),
        .wen        (wen),
        .write_data (write_data),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_full    (tx_full),
        .tx_empty   (tx_empty)
    );

    initial forever #5 clk = ~clk;

    // Baud tick: one cycle high every 16 clocks while enabled, or on request.
    initial forever begin
        bit gen;
        @(posedge clk);
        #3;
        gen = 1'b0;
        if (tick_en) begin
            if (tick_div == 15) begin
                tick_div = 0;
                gen = 1'b1;
            end else begin
                tick_div++;
            end
        end
        tx_tick = gen | manual_tick;
    end

    // Count tx_done pulses.
    initial forever begin
        @(posedge clk);
        #2;
        if (tx_done === 1'b1) done_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [10:0] frame_of(input logic [7:0] d);
        return {1'b1, ^d, d, 1'b0};
    endfunction

    task automatic write_byte(input logic [7:0] d);
        @(posedge clk);
        #1;
        wen = 1'b1;
        write_data = d;
        @(posedge clk);
        #1;
        wen = 1'b0;
    endtask

    // Return #2 after the next clock edge on which tx_tick was sampled high.
    task automatic wait_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(posedge clk);
            if (tx_tick === 1'b1) seen = 1'b1;
        end
        #2;
        if (!seen) begin
            vec_cnt++;
            miss_cnt++;
            $display("FAIL tick_timeout: no baud tick within 64 cycles");
        end
    endtask

    task automatic wait_start();
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            wait_tick();
            if (tx === 1'b0) got = 1'b1;
        end
        vec_cnt++;
        if (!got) begin
            miss_cnt++;
            $display("FAIL start_bit: tx stayed %b for 40 ticks, expected a 0 start bit", tx);
        end
    endtask

    task automatic capture_after_start(output logic [10:0] f);
        f[0] = tx;
        for (int b = 1; b < 11; b++) begin
            wait_tick();
            f[b] = tx;
        end
    endtask

    task automatic capture_next(output logic [10:0] f);
        for (int b = 0; b < 11; b++) begin
            wait_tick();
            f[b] = tx;
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        tick_en = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        vec_cnt++; if (tx !== 1'b1)       begin miss_cnt++; $display("FAIL reset_tx: got %b want 1", tx); end
        vec_cnt++; if (tx_busy !== 1'b0)  begin miss_cnt++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
        vec_cnt++; if (tx_done !== 1'b0)  begin miss_cnt++; $display("FAIL reset_done: got %b want 0", tx_done); end
        vec_cnt++; if (tx_empty !== 1'b1) begin miss_cnt++; $display("FAIL reset_empty: got %b want 1", tx_empty); end
        vec_cnt++; if (tx_full !== 1'b0)  begin miss_cnt++; $display("FAIL reset_full: got %b want 0", tx_full); end
        for (int i = 0; i < 20; i++) begin
            wait_tick();
            if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        vec_cnt++; if (bad != 0) begin miss_cnt++; $display("FAIL reset_quiet: %0d ticks with line activity, want 0", bad); end
    endtask

    task automatic test_single_byte();
        logic [10:0] f;
        int d0 = done_cnt;
        write_byte(8'hA5);
        wait_start();
        capture_after_start(f);
        vec_cnt++; if (f !== 11'b10101001010) begin miss_cnt++; $display("FAIL frame_a5: got %b want %b", f, 11'b10101001010); end
        wait_tick();
        @(posedge clk); #2;
        vec_cnt++; if (done_cnt - d0 != 1) begin miss_cnt++; $display("FAIL done_a5: got %0d pulses want 1", done_cnt - d0); end
        vec_cnt++; if (tx_empty !== 1'b1)  begin miss_cnt++; $display("FAIL empty_a5: got %b want 1", tx_empty); end
        vec_cnt++; if (tx_busy !== 1'b0)   begin miss_cnt++; $display("FAIL busy_a5: got %b want 0", tx_busy); end
    endtask

    task automatic test_odd_weight();
        logic [10:0] f;
        logic [10:0] exp_f = 11'b11000001110;
        int d0 = done_cnt;
        write_byte(8'h07);
        wait_start();
        capture_after_start(f);
        for (int b = 0; b < 11; b++) begin
            vec_cnt++;
            if (f[b] !== exp_f[b]) begin
                miss_cnt++;
                $display("FAIL bit_07[%0d]: got %b want %b", b, f[b], exp_f[b]);
            end
        end
        wait_tick();
        @(posedge clk); #2;
        vec_cnt++; if (done_cnt - d0 != 1) begin miss_cnt++; $display("FAIL done_07: got %0d pulses want 1", done_cnt - d0); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] f;
        int d0;
        tick_en = 1'b0;
        repeat (3) @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            write_byte(8'(k));
            if (k == 7) begin
                vec_cnt++; if (tx_full !== 1'b0) begin miss_cnt++; $display("FAIL full_after_7: got %b want 0", tx_full); end
            end
        end
        vec_cnt++; if (tx_full !== 1'b1) begin miss_cnt++; $display("FAIL full_after_8: got %b want 1", tx_full); end
        write_byte(8'h09);
        vec_cnt++; if (tx_full !== 1'b1) begin miss_cnt++; $display("FAIL full_after_9: got %b want 1", tx_full); end
        d0 = done_cnt;
        tick_en = 1'b1;
        wait_start();
        capture_after_start(f);
        vec_cnt++; if (f !== frame_of(8'h01)) begin miss_cnt++; $display("FAIL b2b_frame1: got %b want %b", f, frame_of(8'h01)); end
        for (int k = 2; k <= 8; k++) begin
            capture_next(f);
            vec_cnt++;
            if (f !== frame_of(8'(k))) begin
                miss_cnt++;
                $display("FAIL b2b_frame%0d: got %b want %b", k, f, frame_of(8'(k)));
            end
        end
        wait_tick();
        @(posedge clk); #2;
        vec_cnt++; if (done_cnt - d0 != 8) begin miss_cnt++; $display("FAIL b2b_done: got %0d pulses want 8", done_cnt - d0); end
        vec_cnt++; if (tx_empty !== 1'b1)  begin miss_cnt++; $display("FAIL b2b_empty: got %b want 1", tx_empty); end
        wait_tick();
        wait_tick();
        vec_cnt++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin miss_cnt++; $display("FAIL b2b_dropped: tx=%b busy=%b want 1/0", tx, tx_busy); end
    endtask

    task automatic test_push_pop_full();
        logic [10:0] f;
        logic [7:0]  exp_b;
        int d0;
        tick_en = 1'b0;
        repeat (3) @(posedge clk);
        for (int k = 0; k < 8; k++) write_byte(8'h11 + 8'(k));
        vec_cnt++; if (tx_full !== 1'b1) begin miss_cnt++; $display("FAIL pp_full: got %b want 1", tx_full); end
        d0 = done_cnt;
        @(posedge clk);
        #1;
        wen = 1'b1;
        write_data = 8'h55;
        manual_tick = 1'b1;
        @(posedge clk);
        #1;
        wen = 1'b0;
        manual_tick = 1'b0;
        #1;
        vec_cnt++; if (tx_full !== 1'b0)  begin miss_cnt++; $display("FAIL pp_not_full: got %b want 0", tx_full); end
        vec_cnt++; if (tx !== 1'b0 || tx_busy !== 1'b1) begin miss_cnt++; $display("FAIL pp_started: tx=%b busy=%b want 0/1", tx, tx_busy); end
        write_byte(8'h66);
        vec_cnt++; if (tx_full !== 1'b1)  begin miss_cnt++; $display("FAIL pp_count7: full=%b want 1 after one more write", tx_full); end
        tick_en = 1'b1;
        capture_after_start(f);
        vec_cnt++; if (f !== frame_of(8'h11)) begin miss_cnt++; $display("FAIL pp_frame0: got %b want %b", f, frame_of(8'h11)); end
        for (int k = 1; k < 9; k++) begin
            exp_b = (k == 8) ? 8'h66 : 8'h11 + 8'(k);
            capture_next(f);
            vec_cnt++;
            if (f !== frame_of(exp_b)) begin
                miss_cnt++;
                $display("FAIL pp_frame%0d: got %b want %b", k, f, frame_of(exp_b));
            end
        end
        wait_tick();
        @(posedge clk); #2;
        vec_cnt++; if (done_cnt - d0 != 9) begin miss_cnt++; $display("FAIL pp_done: got %0d pulses want 9", done_cnt - d0); end
        vec_cnt++; if (tx_empty !== 1'b1)  begin miss_cnt++; $display("FAIL pp_empty: got %b want 1", tx_empty); end
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] f;
        int d0;
        int bad = 0;
        tick_en = 1'b1;
        write_byte(8'h3C);
        wait_start();
        repeat (4) wait_tick();
        vec_cnt++; if (tx !== 1'b1 || tx_busy !== 1'b1) begin miss_cnt++; $display("FAIL mid_bit3: tx=%b busy=%b want 1/1", tx, tx_busy); end
        d0 = done_cnt;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        vec_cnt++; if (tx !== 1'b1)       begin miss_cnt++; $display("FAIL mid_rst_tx: got %b want 1", tx); end
        vec_cnt++; if (tx_busy !== 1'b0)  begin miss_cnt++; $display("FAIL mid_rst_busy: got %b want 0", tx_busy); end
        vec_cnt++; if (tx_empty !== 1'b1) begin miss_cnt++; $display("FAIL mid_rst_empty: got %b want 1", tx_empty); end
        for (int i = 0; i < 12; i++) begin
            wait_tick();
            if (tx !== 1'b1) bad++;
        end
        @(posedge clk); #2;
        vec_cnt++; if (bad != 0)       begin miss_cnt++; $display("FAIL mid_no_resume: %0d ticks with tx low, want 0", bad); end
        vec_cnt++; if (done_cnt != d0) begin miss_cnt++; $display("FAIL mid_no_done: got %0d pulses want 0", done_cnt - d0); end
        write_byte(8'h81);
        wait_start();
        capture_after_start(f);
        vec_cnt++; if (f !== 11'b10100000010) begin miss_cnt++; $display("FAIL frame_81: got %b want %b", f, 11'b10100000010); end
        wait_tick();
        @(posedge clk); #2;
        vec_cnt++; if (done_cnt - d0 != 1) begin miss_cnt++; $display("FAIL done_81: got %0d pulses want 1", done_cnt - d0); end
        vec_cnt++; if (tx_busy !== 1'b0)   begin miss_cnt++; $display("FAIL busy_81: got %b want 0", tx_busy); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_odd_weight();
        test_back_to_back();
        test_push_pop_full();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
